// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: channel modes, per-channel
// config record and reset defaults.
package led_pattern_pkg;

    // Config fields are carried at a fixed width; channels compare against
    // zero-extended counters, so unused upper bits stay constant zero.
    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e            mode;
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] duty;
    } cfg_t;

    localparam mode_e            RST_MODE = MODE_BLINK;
    localparam logic [CFG_W-1:0] RST_DUTY = '0;

    function automatic cfg_t cfg_reset(input logic [CFG_W-1:0] period);
        cfg_t c;
        c.mode   = RST_MODE;
        c.period = period;
        c.duty   = RST_DUTY;
        return c;
    endfunction

    // LED level on the edge a config becomes active (counter restarts at 0).
    function automatic logic start_level(input cfg_t c);
        case (c.mode)
            MODE_OFF: return 1'b0;
            MODE_PWM: return c.duty != '0;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Runtime config write port: one channel's mode/period/duty per accepted beat.
interface led_pattern_gen_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 17
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: wrap counter, double-buffered config and led/wrap drive.
// New settings land only at a wrap (or next tick when idle in OFF/ON).
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int CNT_W      = 17,
    parameter int DEF_PERIOD = 600
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic wr,
    input  cfg_t wr_cfg,
    output logic led,
    output logic wrap_pulse
);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

    cfg_t             act, pnd, nxt_cfg;
    logic             pend, running, wrap, adopt, led_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        running = (act.mode == MODE_BLINK) || (act.mode == MODE_PWM);
        wrap    = tick && running && (CFG_W'(cnt) == act.period);
        adopt   = tick && (wrap || !running) && (pend || wr);
        // A write arriving on the adoption edge bypasses the pending slot.
        nxt_cfg = wr ? wr_cfg : pnd;

        cnt_nxt = cnt;
        if (adopt || wrap)
            cnt_nxt = '0;
        else if (tick && running)
            cnt_nxt = cnt + 1'b1;

        led_nxt = led;
        if (adopt)
            led_nxt = start_level(nxt_cfg);
        else begin
            case (act.mode)
                MODE_OFF:   led_nxt = 1'b0;
                MODE_ON:    led_nxt = 1'b1;
                MODE_BLINK: if (wrap) led_nxt = ~led;
                MODE_PWM:   led_nxt = CFG_W'(cnt_nxt) < act.duty;
                default:    led_nxt = led;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act        <= cfg_reset(CFG_W'(DEF_P));
            pnd        <= cfg_reset(CFG_W'(DEF_P));
            pend       <= 1'b0;
            cnt        <= '0;
            led        <= 1'b1;
            wrap_pulse <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            led        <= led_nxt;
            wrap_pulse <= wrap;
            if (adopt) begin
                act  <= nxt_cfg;
                pend <= 1'b0;
            end else if (wr) begin
                pnd  <= wr_cfg;
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler, config decode and
// an array of independent led_channel instances.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int CNT_W      = 17,
    parameter int PRESCALE   = 1,
    parameter int DEF_PERIOD = 600
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    led_pattern_gen_if.slave  cfg,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   wrap_pulse
);
    localparam int              CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;
    logic            tick, accept;
    cfg_t            wcfg;

    assign tick          = (ps_cnt == PS_LAST);
    assign cfg.cfg_ready = ~sys_rst;
    assign accept        = cfg.cfg_valid && ~sys_rst;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + 1'b1;
    end

    always_comb begin
        wcfg.mode   = mode_e'(cfg.cfg_mode);
        wcfg.period = CFG_W'(cfg.cfg_period);
        wcfg.duty   = CFG_W'(cfg.cfg_duty);
    end

    // Channel indices at or above N_CH match no instance and are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);
        led_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk        (sys_clk),
            .rst        (sys_rst),
            .tick       (tick),
            .wr         (accept && (cfg.cfg_ch == IDX)),
            .wr_cfg     (wcfg),
            .led        (led[i]),
            .wrap_pulse (wrap_pulse[i])
        );
    end

endmodule
